// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
// Hazard and forwarding controller for a 5-stage IF/ID/EX/MEM/WB pipeline.
// Tracks the EX, MEM and WB occupants as tags and derives from them:
//   - PC / IF-ID enables
//   - IF-ID, ID-EX and EX-MEM flushes
//   - single-cycle load-use stalls
//   - EX-stage operand forwarding selects
//
// Optional feature: define HAZARD_PERF_CNT_EN to build the stall/flush
// performance counters. Without it, o_stall_cnt and o_flush_cnt are tied to 0.
//
// Parameters:
//   REG_AW   register address width (register 0 is hard-wired zero)
//   CNT_W    performance counter width
//   BR_STAGE stage resolving branches: 1 = EX, 2 = MEM
//
// Ports:
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_ext_stall           external freeze request (highest priority)
//   i_id_*                decoded fields of the instruction currently in ID
//   i_br_taken            taken branch resolved in BR_STAGE
//   o_pc_en, o_ifid_en    PC / IF-ID register enables
//   o_ifid_flush          IF-ID clear
//   o_idex_bubble         ID-EX loads a NOP
//   o_exmem_flush         EX-MEM loads a NOP (BR_STAGE = 2 only)
//   o_fwd_a, o_fwd_b      EX operand selects: 00 regfile, 10 EX/MEM, 01 MEM/WB
//   o_stall_cnt           load-use stall cycles
//   o_flush_cnt           taken-branch flushes
module pipe_hazard_ctrl #(
  parameter int unsigned REG_AW   = 5,
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned BR_STAGE = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_ext_stall,
  input  logic              i_id_valid,
  input  logic [REG_AW-1:0] i_id_rs,
  input  logic [REG_AW-1:0] i_id_rt,
  input  logic              i_id_use_rs,
  input  logic              i_id_use_rt,
  input  logic [REG_AW-1:0] i_id_dest,
  input  logic              i_id_regwrite,
  input  logic              i_id_is_load,
  input  logic              i_br_taken,
  output logic              o_pc_en,
  output logic              o_ifid_en,
  output logic              o_ifid_flush,
  output logic              o_idex_bubble,
  output logic              o_exmem_flush,
  output logic [1:0]        o_fwd_a,
  output logic [1:0]        o_fwd_b,
  output logic [CNT_W-1:0]  o_stall_cnt,
  output logic [CNT_W-1:0]  o_flush_cnt
);

  // Branch resolved in MEM means the EX/MEM occupant is also wrong-path.
  localparam logic BR_IN_MEM = (BR_STAGE == 2);

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;

  typedef struct packed {
    logic              valid;
    logic              regwrite;
    logic              is_load;
    logic [REG_AW-1:0] dest;
  } tag_t;

  typedef struct packed {
    tag_t              base;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic              use_rs;
    logic              use_rt;
  } ex_tag_t;

  // How the tag pipeline moves on the next edge.
  typedef enum logic [1:0] {
    ADV_RUN,
    ADV_STALL,
    ADV_FLUSH,
    ADV_FREEZE
  } adv_e;

  ex_tag_t ex_q, ex_n;
  tag_t    mem_q, mem_n;
  tag_t    wb_q, wb_n;
  adv_e    adv_c;
  logic    load_use_c;

  // The load flag has no consumer once an instruction reaches WB.
  logic    wb_is_load_unused;
  assign wb_is_load_unused = wb_q.is_load;

  // Nearest older producer of src, or register file when none / src is r0.
  function automatic logic [1:0] fwd_sel(
    input logic              en,
    input logic [REG_AW-1:0] src,
    input tag_t              mem,
    input tag_t              wb
  );
    logic [1:0] sel;
    sel = FWD_RF;
    if (en && (src != '0)) begin
      if (mem.valid && mem.regwrite && (mem.dest != '0) && (mem.dest == src)) begin
        sel = FWD_EXMEM;
      end else if (wb.valid && wb.regwrite && (wb.dest != '0) && (wb.dest == src)) begin
        sel = FWD_MEMWB;
      end
    end
    return sel;
  endfunction

  // Consumer in ID needs a load result that is still in EX.
  always_comb begin
    load_use_c = 1'b0;
    if (i_id_valid && ex_q.base.valid && ex_q.base.is_load &&
        ex_q.base.regwrite && (ex_q.base.dest != '0)) begin
      load_use_c = (i_id_use_rs && (i_id_rs == ex_q.base.dest)) ||
                   (i_id_use_rt && (i_id_rt == ex_q.base.dest));
    end
  end

  // Priority: external freeze, taken branch, load-use, normal advance.
  always_comb begin
    adv_c = ADV_RUN;
    if (i_ext_stall) begin
      adv_c = ADV_FREEZE;
    end else if (i_br_taken) begin
      adv_c = ADV_FLUSH;
    end else if (load_use_c) begin
      adv_c = ADV_STALL;
    end
  end

  // Enable / flush outputs and next tag contents.
  always_comb begin
    o_pc_en       = 1'b1;
    o_ifid_en     = 1'b1;
    o_ifid_flush  = 1'b0;
    o_idex_bubble = 1'b0;
    o_exmem_flush = 1'b0;
    ex_n          = ex_q;
    mem_n         = mem_q;
    wb_n          = wb_q;
    case (adv_c)
      ADV_FREEZE: begin
        o_pc_en   = 1'b0;
        o_ifid_en = 1'b0;
      end
      ADV_FLUSH: begin
        o_ifid_flush  = 1'b1;
        o_idex_bubble = 1'b1;
        o_exmem_flush = BR_IN_MEM;
        ex_n          = '0;
        mem_n         = BR_IN_MEM ? tag_t'('0) : ex_q.base;
        wb_n          = mem_q;
      end
      ADV_STALL: begin
        o_pc_en       = 1'b0;
        o_ifid_en     = 1'b0;
        o_idex_bubble = 1'b1;
        ex_n          = '0;
        mem_n         = ex_q.base;
        wb_n          = mem_q;
      end
      default: begin
        ex_n.base.valid    = i_id_valid;
        ex_n.base.regwrite = i_id_regwrite;
        ex_n.base.is_load  = i_id_is_load;
        ex_n.base.dest     = i_id_dest;
        ex_n.rs            = i_id_rs;
        ex_n.rt            = i_id_rt;
        ex_n.use_rs        = i_id_use_rs;
        ex_n.use_rt        = i_id_use_rt;
        mem_n              = ex_q.base;
        wb_n               = mem_q;
      end
    endcase
  end

  // Tag shift register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q  <= ex_n;
      mem_q <= mem_n;
      wb_q  <= wb_n;
    end
  end

  // Forwarding selects for the EX occupant.
  always_comb begin
    o_fwd_a = FWD_RF;
    o_fwd_b = FWD_RF;
    if (ex_q.base.valid) begin
      o_fwd_a = fwd_sel(ex_q.use_rs, ex_q.rs, mem_q, wb_q);
      o_fwd_b = fwd_sel(ex_q.use_rt, ex_q.rt, mem_q, wb_q);
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  // Free-running wrap-around event counters.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (adv_c == ADV_STALL) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      if (adv_c == ADV_FLUSH) begin
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
    end
  end

  assign o_stall_cnt = stall_cnt_q;
  assign o_flush_cnt = flush_cnt_q;
`else
  assign o_stall_cnt = '0;
  assign o_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

  localparam int unsigned REG_AW   = 5;
  localparam int unsigned CNT_W    = 16;
  localparam int unsigned BR_STAGE = 2;

  logic              clk;
  logic              rst_n;
  logic              ext_stall;
  logic              id_valid;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic              id_use_rs;
  logic              id_use_rt;
  logic [REG_AW-1:0] id_dest;
  logic              id_regwrite;
  logic              id_is_load;
  logic              br_taken;
  logic              pc_en;
  logic              ifid_en;
  logic              ifid_flush;
  logic              idex_bubble;
  logic              exmem_flush;
  logic [1:0]        fwd_a;
  logic [1:0]        fwd_b;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  pipe_hazard_ctrl #(
    .REG_AW  (REG_AW),
    .CNT_W   (CNT_W),
    .BR_STAGE(BR_STAGE)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_ext_stall  (ext_stall),
    .i_id_valid   (id_valid),
    .i_id_rs      (id_rs),
    .i_id_rt      (id_rt),
    .i_id_use_rs  (id_use_rs),
    .i_id_use_rt  (id_use_rt),
    .i_id_dest    (id_dest),
    .i_id_regwrite(id_regwrite),
    .i_id_is_load (id_is_load),
    .i_br_taken   (br_taken),
    .o_pc_en      (pc_en),
    .o_ifid_en    (ifid_en),
    .o_ifid_flush (ifid_flush),
    .o_idex_bubble(idex_bubble),
    .o_exmem_flush(exmem_flush),
    .o_fwd_a      (fwd_a),
    .o_fwd_b      (fwd_b),
    .o_stall_cnt  (stall_cnt),
    .o_flush_cnt  (flush_cnt)
  );

  // {pc_en, ifid_en, ifid_flush, idex_bubble, exmem_flush}
  wire [4:0] ctl = {pc_en, ifid_en, ifid_flush, idex_bubble, exmem_flush};
  wire [3:0] fwd = {fwd_a, fwd_b};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp;
  int n_mis;

  // Reference model: the three in-flight instructions, oldest last.
  typedef struct {
    bit v, rw, ld, urs, urt;
    int dest, rs, rt;
  } ins_t;

  ins_t m_ex, m_mem, m_wb;
  int   m_stall, m_flush;

  function automatic ins_t bubble();
    ins_t b;
    b = '{default: 0};
    return b;
  endfunction

  function automatic ins_t id_ins();
    ins_t i;
    i.v = id_valid; i.rw = id_regwrite; i.ld = id_is_load;
    i.urs = id_use_rs; i.urt = id_use_rt;
    i.dest = int'(id_dest); i.rs = int'(id_rs); i.rt = int'(id_rt);
    return i;
  endfunction

  function automatic void model_reset();
    m_ex = bubble(); m_mem = bubble(); m_wb = bubble();
    m_stall = 0; m_flush = 0;
  endfunction

  function automatic bit m_hazard();
    bit reads;
    reads = (id_use_rs && int'(id_rs) == m_ex.dest) || (id_use_rt && int'(id_rt) == m_ex.dest);
    return id_valid && m_ex.v && m_ex.ld && m_ex.rw && m_ex.dest != 0 && reads;
  endfunction

  // Youngest older writer of src wins; r0 never forwards.
  function automatic logic [1:0] m_fwd(input int src, input bit en);
    ins_t older[2];
    if (!m_ex.v || !en || src == 0) return 2'b00;
    older = '{m_mem, m_wb};
    for (int k = 0; k < 2; k++) begin
      if (older[k].v && older[k].rw && older[k].dest == src) return (k == 0) ? 2'b10 : 2'b01;
    end
    return 2'b00;
  endfunction

  function automatic logic [4:0] exp_ctl();
    if (ext_stall) return 5'b00000;
    if (br_taken) return {4'b1111, (BR_STAGE == 2)};
    if (m_hazard()) return 5'b00010;
    return 5'b11000;
  endfunction

  function automatic logic [3:0] exp_fwd();
    return {m_fwd(m_ex.rs, m_ex.urs), m_fwd(m_ex.rt, m_ex.urt)};
  endfunction

  function automatic logic [CNT_W-1:0] cnt_exp(input int n);
`ifdef HAZARD_PERF_CNT_EN
    return CNT_W'(n);
`else
    return (n == -1) ? CNT_W'(1) : '0;
`endif
  endfunction

  function automatic void model_step();
    bit hz;
    if (!rst_n) return;
    hz = m_hazard();
    if (ext_stall) begin
      return;
    end else if (br_taken) begin
      m_wb  = m_mem;
      m_mem = (BR_STAGE == 2) ? bubble() : m_ex;
      m_ex  = bubble();
      m_flush++;
    end else if (hz) begin
      m_wb  = m_mem;
      m_mem = m_ex;
      m_ex  = bubble();
      m_stall++;
    end else begin
      m_wb  = m_mem;
      m_mem = m_ex;
      m_ex  = id_ins();
    end
  endfunction

  task automatic drive(input bit ext, input bit v, input int rs, input int rt,
                       input bit urs, input bit urt, input int dest,
                       input bit rw, input bit ld, input bit br);
    @(negedge clk);
    ext_stall = ext; id_valid = v;
    id_rs = REG_AW'(rs); id_rt = REG_AW'(rt);
    id_use_rs = urs; id_use_rt = urt;
    id_dest = REG_AW'(dest); id_regwrite = rw; id_is_load = ld;
    br_taken = br;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    ext_stall = 0; id_valid = 0; id_rs = '0; id_rt = '0; id_use_rs = 0; id_use_rt = 0;
    id_dest = '0; id_regwrite = 0; id_is_load = 0; br_taken = 0;
    model_reset();
    #3;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    for (int c = 0; c < 3; c++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      n_cmp++;
      if (ctl !== 5'b11000) begin
        n_mis++; $display("FAIL reset_ctl got %b want %b", ctl, 5'b11000);
      end
      n_cmp++;
      if (fwd !== 4'b0000) begin
        n_mis++; $display("FAIL reset_fwd got %b want %b", fwd, 4'b0000);
      end
      tick();
    end
    n_cmp++;
    if (stall_cnt !== '0 || flush_cnt !== '0) begin
      n_mis++; $display("FAIL reset_cnt got %0d/%0d want 0/0", stall_cnt, flush_cnt);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    drive(0, 1, 0, 0, 0, 0, 5, 1, 1, 0);   // load r5
    tick();
    drive(0, 1, 5, 0, 1, 0, 6, 1, 0, 0);   // consumer of r5
    n_cmp++;
    if (ctl !== 5'b00010) begin
      n_mis++; $display("FAIL ld_use_stall ctl got %b want %b", ctl, 5'b00010);
    end
    tick();
    n_cmp++;
    if (stall_cnt !== cnt_exp(1)) begin
      n_mis++; $display("FAIL ld_use_cnt got %0d want %0d", stall_cnt, cnt_exp(1));
    end
    drive(0, 1, 5, 0, 1, 0, 6, 1, 0, 0);   // consumer held in ID
    n_cmp++;
    if (ctl !== 5'b11000) begin
      n_mis++; $display("FAIL ld_use_one_cycle ctl got %b want %b", ctl, 5'b11000);
    end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    n_cmp++;
    if (fwd_a !== 2'b01) begin
      n_mis++; $display("FAIL ld_use_fwd got %b want %b", fwd_a, 2'b01);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    do_reset();
    drive(0, 1, 1, 2, 1, 1, 3, 1, 0, 0);
    tick();
    drive(0, 1, 1, 2, 1, 1, 3, 1, 0, 0);
    tick();
    drive(0, 1, 3, 3, 1, 1, 4, 1, 0, 0);
    n_cmp++;
    if (ctl !== 5'b11000) begin
      n_mis++; $display("FAIL b2b_nostall got %b want %b", ctl, 5'b11000);
    end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    n_cmp++;
    if (fwd !== 4'b1010) begin
      n_mis++; $display("FAIL b2b_fwd got %b want %b", fwd, 4'b1010);
    end
    tick();
    n_cmp++;
    if (fwd !== exp_fwd()) begin
      n_mis++; $display("FAIL b2b_drain got %b want %b", fwd, exp_fwd());
    end
  endtask

  task automatic test_reg_zero();
    do_reset();
    drive(0, 1, 0, 0, 0, 0, 0, 1, 1, 0);   // load to r0
    tick();
    drive(0, 1, 0, 0, 1, 1, 7, 1, 0, 0);   // reads r0
    n_cmp++;
    if (ctl !== 5'b11000) begin
      n_mis++; $display("FAIL r0_nostall got %b want %b", ctl, 5'b11000);
    end
    tick();
    drive(0, 1, 0, 0, 0, 0, 0, 1, 0, 0);   // ALU to r0
    n_cmp++;
    if (fwd !== 4'b0000) begin
      n_mis++; $display("FAIL r0_fwd_load got %b want %b", fwd, 4'b0000);
    end
    tick();
    drive(0, 1, 0, 0, 1, 0, 8, 1, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    n_cmp++;
    if (fwd !== 4'b0000) begin
      n_mis++; $display("FAIL r0_fwd_alu got %b want %b", fwd, 4'b0000);
    end
    tick();
  endtask

  task automatic test_branch();
    int st0, fl0;
    do_reset();
    drive(0, 1, 0, 0, 0, 0, 7, 1, 1, 0);   // load r7
    tick();
    st0 = m_stall; fl0 = m_flush;
    drive(0, 1, 7, 0, 1, 0, 9, 1, 0, 1);   // load-use plus taken branch
    n_cmp++;
    if (ctl !== {4'b1111, (BR_STAGE == 2)}) begin
      n_mis++; $display("FAIL br_ctl got %b want %b", ctl, {4'b1111, (BR_STAGE == 2)});
    end
    tick();
    n_cmp++;
    if (flush_cnt !== cnt_exp(fl0 + 1) || stall_cnt !== cnt_exp(st0)) begin
      n_mis++; $display("FAIL br_cnt got %0d/%0d want %0d/%0d", flush_cnt, stall_cnt,
                        cnt_exp(fl0 + 1), cnt_exp(st0));
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    n_cmp++;
    if (fwd !== 4'b0000) begin
      n_mis++; $display("FAIL br_ex_killed got %b want %b", fwd, 4'b0000);
    end
    tick();
  endtask

  task automatic test_ext_stall_branch();
    do_reset();
    drive(0, 1, 0, 0, 0, 0, 4, 1, 0, 0);   // ALU r4
    tick();
    drive(0, 1, 4, 0, 1, 0, 6, 1, 0, 0);   // consumer of r4
    tick();
    for (int c = 0; c < 2; c++) begin
      drive(1, 1, 4, 0, 1, 0, 6, 1, 0, 1);
      n_cmp++;
      if (ctl !== 5'b00000) begin
        n_mis++; $display("FAIL xs_ctl[%0d] got %b want %b", c, ctl, 5'b00000);
      end
      n_cmp++;
      if (fwd_a !== 2'b10) begin
        n_mis++; $display("FAIL xs_hold[%0d] got %b want %b", c, fwd_a, 2'b10);
      end
      tick();
    end
    n_cmp++;
    if (flush_cnt !== cnt_exp(0)) begin
      n_mis++; $display("FAIL xs_cnt_hold got %0d want %0d", flush_cnt, cnt_exp(0));
    end
    drive(0, 1, 4, 0, 1, 0, 6, 1, 0, 1);   // released: branch acts now
    n_cmp++;
    if (ctl !== exp_ctl() || ifid_flush !== 1'b1) begin
      n_mis++; $display("FAIL xs_release got %b want %b", ctl, exp_ctl());
    end
    tick();
    n_cmp++;
    if (flush_cnt !== cnt_exp(1)) begin
      n_mis++; $display("FAIL xs_flush_cnt got %0d want %0d", flush_cnt, cnt_exp(1));
    end
    // Rebuild a forwarding state, freeze, then reset in the middle of the freeze.
    drive(0, 1, 0, 0, 0, 0, 4, 1, 0, 0);
    tick();
    drive(0, 1, 4, 0, 1, 0, 6, 1, 0, 0);
    tick();
    drive(1, 1, 4, 0, 1, 0, 6, 1, 0, 1);
    n_cmp++;
    if (fwd_a !== 2'b10) begin
      n_mis++; $display("FAIL xs_rst_pre got %b want %b", fwd_a, 2'b10);
    end
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    n_cmp++;
    if (fwd !== 4'b0000 || stall_cnt !== '0 || flush_cnt !== '0) begin
      n_mis++; $display("FAIL xs_rst_clear fwd %b cnt %0d/%0d want 0000 0/0", fwd, stall_cnt, flush_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1; ext_stall = 0; br_taken = 0; id_valid = 0;
  endtask

  task automatic test_random();
    bit prev_ext, prev_br, ext, br;
    do_reset();
    prev_ext = 0; prev_br = 0;
    for (int c = 0; c < 800; c++) begin
      ext = ($urandom_range(7) == 0);
      br  = (prev_ext && prev_br) ? 1'b1 : ($urandom_range(9) == 0);
      drive(ext, $urandom_range(5) != 0, int'($urandom_range(3)), int'($urandom_range(3)),
            $urandom_range(1) == 1, $urandom_range(1) == 1, int'($urandom_range(3)),
            $urandom_range(3) != 0, $urandom_range(2) == 0, br);
      n_cmp++;
      if (ctl !== exp_ctl()) begin
        n_mis++; $display("FAIL rnd_ctl[%0d] got %b want %b", c, ctl, exp_ctl());
      end
      n_cmp++;
      if (fwd !== exp_fwd()) begin
        n_mis++; $display("FAIL rnd_fwd[%0d] got %b want %b", c, fwd, exp_fwd());
      end
      tick();
      n_cmp++;
      if (stall_cnt !== cnt_exp(m_stall) || flush_cnt !== cnt_exp(m_flush)) begin
        n_mis++; $display("FAIL rnd_cnt[%0d] got %0d/%0d want %0d/%0d", c, stall_cnt, flush_cnt,
                          cnt_exp(m_stall), cnt_exp(m_flush));
      end
      prev_ext = ext; prev_br = br;
    end
  endtask

  initial begin
    n_cmp = 0;
    n_mis = 0;
    rst_n = 1'b0;
    model_reset();
    test_reset();
    test_load_use();
    test_back_to_back();
    test_reg_zero();
    test_branch();
    test_ext_stall_branch();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
